player_dir_ctrl: RTL

PLAYER_DIR_CTRL -- requirements
Module: player_dir_ctrl

---
 rtl/player_dir_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/player_dir_ctrl.sv
// Player heading controller: debounces the direction pads and runs the ARMED/RUN/DEAD round FSM.
// Optional macro PLAYER_REVERSE_BLOCK_EN discards 180-degree turns while running.
module player_dir_ctrl #(
    parameter logic [3:0]  INIT_DIR        = 4'b0001,
    parameter int unsigned DEBOUNCE_CYCLES = 400000,
    parameter int unsigned STEP_CYCLES     = 666666
) (
    input  logic       clk_40MHz,
    input  logic       reset,
    input  logic       game_rst,
    input  logic [3:0] pad,
    input  logic       collided,
    output logic [3:0] dir,
    output logic       move_tick,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        ST_ARMED = 2'b00,
        ST_RUN   = 2'b01,
        ST_DEAD  = 2'b10
    } state_t;

    localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] STEP_LAST = 24'(STEP_CYCLES - 1);

    logic [3:0]  cand;
    logic [19:0] deb_cnt;
    logic [3:0]  stable;
    logic [3:0]  stable_q;
    logic        press;

    state_t      state, state_d;
    logic [3:0]  dir_q, dir_d;
    logic [23:0] step_cnt, step_d;
    logic        reverse_blocked;

    // Counter holds at DEB_LAST, so stable keeps reloading the same candidate harmlessly.
    always_ff @(posedge clk_40MHz or posedge reset) begin
        if (reset) begin
            cand     <= '0;
            deb_cnt  <= '0;
            stable   <= '0;
            stable_q <= '0;
        end else if (game_rst) begin
            cand     <= '0;
            deb_cnt  <= '0;
            stable   <= '0;
            stable_q <= '0;
        end else begin
            stable_q <= stable;
            if (pad != cand) begin
                cand    <= pad;
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                stable  <= cand;
            end else begin
                deb_cnt <= deb_cnt + 20'd1;
            end
        end
    end

    assign press = (stable != stable_q) && $onehot(stable);

`ifdef PLAYER_REVERSE_BLOCK_EN
    assign reverse_blocked = (stable == {dir_q[2], dir_q[3], dir_q[0], dir_q[1]});
`else
    assign reverse_blocked = 1'b0;
`endif

    always_ff @(posedge clk_40MHz or posedge reset) begin
        if (reset) begin
            state    <= ST_ARMED;
            dir_q    <= INIT_DIR;
            step_cnt <= '0;
        end else begin
            state    <= state_d;
            dir_q    <= dir_d;
            step_cnt <= step_d;
        end
    end

    always_comb begin
        state_d = state;
        dir_d   = dir_q;
        step_d  = step_cnt;
        if (game_rst) begin
            state_d = ST_ARMED;
            dir_d   = INIT_DIR;
            step_d  = '0;
        end else begin
            case (state)
                ST_ARMED: begin
                    step_d = '0;
                    if (press) begin
                        dir_d   = stable;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (collided) begin
                        state_d = ST_DEAD;
                        dir_d   = '0;
                        step_d  = '0;
                    end else begin
                        step_d = (step_cnt == STEP_LAST) ? '0 : step_cnt + 24'd1;
                        if (press && !reverse_blocked)
                            dir_d = stable;
                    end
                end
                ST_DEAD: begin
                    dir_d  = '0;
                    step_d = '0;
                end
                default: begin
                    state_d = ST_ARMED;
                    dir_d   = INIT_DIR;
                    step_d  = '0;
                end
            endcase
        end
    end

    assign dir        = dir_q;
    assign game_state = state;
    assign move_tick  = (state == ST_RUN) && (step_cnt == STEP_LAST);

endmodule
